// File: rtl/control_unit.sv
// Control FSM for the 8-bit accumulator CPU: sequences fetch, decode and execute
// and drives the datapath strobes from the registered state, IR and CCR flags.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [3:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       ALU_B_Sel,
  output logic       write,
  output logic       halted
);

  localparam logic [3:0] FETCH_0  = 4'd0;
  localparam logic [3:0] FETCH_1  = 4'd1;
  localparam logic [3:0] FETCH_2  = 4'd2;
  localparam logic [3:0] DECODE_3 = 4'd3;
  localparam logic [3:0] EXEC_4   = 4'd4;
  localparam logic [3:0] EXEC_5   = 4'd5;
  localparam logic [3:0] EXEC_6   = 4'd6;
  localparam logic [3:0] EXEC_7   = 4'd7;
  localparam logic [3:0] EXEC_8   = 4'd8;
  localparam logic [3:0] HALT     = 4'd9;

  localparam logic [7:0] LDA_IMM = 8'h86, LDA_DIR = 8'h87, LDB_IMM = 8'h88, LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96, STB_DIR = 8'h97;
  localparam logic [7:0] ADD_AB  = 8'h42, SUB_AB  = 8'h43, AND_AB  = 8'h44, OR_AB = 8'h45;
  localparam logic [7:0] INCA    = 8'h46, DECA    = 8'h47;
  localparam logic [7:0] BRA     = 8'h20, BMI     = 8'h21, BEQ     = 8'h23, BNE   = 8'h24;
  localparam logic [7:0] BCS     = 8'h25;

  logic [3:0] state, next_state;

  // The V flag has no branch that tests it.
  logic unused_ccr_v;
  assign unused_ccr_v = CCR_Result[1];

  function automatic logic is_alu(input logic [7:0] op);
    return op inside {ADD_AB, SUB_AB, AND_AB, OR_AB, INCA, DECA};
  endfunction

  function automatic logic is_branch(input logic [7:0] op);
    return op inside {BRA, BMI, BEQ, BNE, BCS};
  endfunction

  function automatic logic is_ld_imm(input logic [7:0] op);
    return op inside {LDA_IMM, LDB_IMM};
  endfunction

  function automatic logic is_ld_dir(input logic [7:0] op);
    return op inside {LDA_DIR, LDB_DIR};
  endfunction

  function automatic logic is_st_dir(input logic [7:0] op);
    return op inside {STA_DIR, STB_DIR};
  endfunction

  function automatic logic uses_a(input logic [7:0] op);
    return op inside {LDA_IMM, LDA_DIR, STA_DIR};
  endfunction

  function automatic logic [3:0] alu_code(input logic [7:0] op);
    case (op)
      SUB_AB:  return 4'b0001;
      AND_AB:  return 4'b0010;
      OR_AB:   return 4'b0011;
      INCA:    return 4'b0100;
      DECA:    return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] ccr);
    case (op)
      BRA:     return 1'b1;
      BMI:     return ccr[3];
      BEQ:     return ccr[2];
      BNE:     return ~ccr[2];
      BCS:     return ccr[0];
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH_0;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH_0;
    case (state)
      FETCH_0:  next_state = FETCH_1;
      FETCH_1:  next_state = FETCH_2;
      FETCH_2:  next_state = DECODE_3;
      DECODE_3: next_state = (is_alu(IR) || is_branch(IR) || is_ld_imm(IR) ||
                              is_ld_dir(IR) || is_st_dir(IR)) ? EXEC_4 : HALT;
      EXEC_4:   next_state = is_alu(IR) ? FETCH_0 : EXEC_5;
      EXEC_5:   next_state = EXEC_6;
      EXEC_6:   next_state = (is_ld_dir(IR) || is_st_dir(IR)) ? EXEC_7 : FETCH_0;
      EXEC_7:   next_state = is_ld_dir(IR) ? EXEC_8 : FETCH_0;
      EXEC_8:   next_state = FETCH_0;
      HALT:     next_state = HALT;
      default:  next_state = FETCH_0;
    endcase
  end

  logic ir_load_c, mar_load_c, pc_load_c, pc_inc_c, a_load_c, b_load_c, ccr_load_c;
  logic write_c, halted_c;

  always_comb begin
    ir_load_c  = 1'b0;
    mar_load_c = 1'b0;
    pc_load_c  = 1'b0;
    pc_inc_c   = 1'b0;
    a_load_c   = 1'b0;
    b_load_c   = 1'b0;
    ccr_load_c = 1'b0;
    write_c    = 1'b0;
    halted_c   = 1'b0;
    ALU_Sel    = 4'b0000;
    Bus1_Sel   = 2'b00;
    Bus2_Sel   = 2'b00;
    ALU_B_Sel  = 1'b0;
    case (state)
      FETCH_0: begin
        Bus2_Sel   = 2'b01;
        mar_load_c = 1'b1;
      end
      FETCH_1: pc_inc_c = 1'b1;
      FETCH_2: begin
        Bus2_Sel  = 2'b10;
        ir_load_c = 1'b1;
      end
      EXEC_4: begin
        if (is_alu(IR)) begin
          Bus1_Sel   = 2'b01;
          ALU_Sel    = alu_code(IR);
          a_load_c   = 1'b1;
          ccr_load_c = 1'b1;
        end else begin
          Bus2_Sel   = 2'b01;
          mar_load_c = 1'b1;
        end
      end
      EXEC_5: pc_inc_c = ~is_branch(IR);
      EXEC_6: begin
        if (is_branch(IR)) begin
          // Taken branches load PC through the datapath's relative adder.
          if (branch_taken(IR, CCR_Result)) begin
            Bus2_Sel  = 2'b10;
            pc_load_c = 1'b1;
          end else begin
            pc_inc_c  = 1'b1;
          end
        end else if (is_ld_imm(IR)) begin
          Bus2_Sel = 2'b10;
          a_load_c = uses_a(IR);
          b_load_c = ~uses_a(IR);
        end else begin
          Bus2_Sel   = 2'b10;
          mar_load_c = 1'b1;
        end
      end
      EXEC_7: begin
        if (is_st_dir(IR)) begin
          Bus1_Sel = uses_a(IR) ? 2'b01 : 2'b10;
          write_c  = 1'b1;
        end
      end
      EXEC_8: begin
        Bus2_Sel = 2'b10;
        a_load_c = uses_a(IR);
        b_load_c = ~uses_a(IR);
      end
      HALT:    halted_c = 1'b1;
      default: ;
    endcase
  end

  // Strobes are held off for as long as reset is high, even though the state is already FETCH_0.
  assign IR_Load  = ir_load_c  & ~reset;
  assign MAR_Load = mar_load_c & ~reset;
  assign PC_Load  = pc_load_c  & ~reset;
  assign PC_Inc   = pc_inc_c   & ~reset;
  assign A_Load   = a_load_c   & ~reset;
  assign B_Load   = b_load_c   & ~reset;
  assign CCR_Load = ccr_load_c & ~reset;
  assign write    = write_c    & ~reset;
  assign halted   = halted_c   & ~reset;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural datapath and memory run programs, while a
// queue of expected per-cycle strobe vectors is compared against the DUT outputs.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ir_m = 8'h00;
  logic [3:0] ccr_m = 4'h0;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [3:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       ALU_B_Sel, write, halted;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(ir_m), .CCR_Result(ccr_m),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .ALU_B_Sel(ALU_B_Sel),
    .write(write), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                    ALU_Sel, Bus1_Sel, Bus2_Sel, ALU_B_Sel, write, halted};

  localparam logic [6:0] S_0   = 7'b0000000, S_IR = 7'b1000000, S_MAR = 7'b0100000;
  localparam logic [6:0] S_PCL = 7'b0010000, S_PCI = 7'b0001000, S_A = 7'b0000100;
  localparam logic [6:0] S_B   = 7'b0000010, S_CCR = 7'b0000001;

  logic [7:0] mem [256];
  logic [7:0] pc_m, mar_m, a_m, b_m;
  logic [17:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_halt = 0;

  logic [7:0] br_op    [9] = '{8'h23, 8'h23, 8'h24, 8'h24, 8'h21, 8'h21, 8'h25, 8'h25, 8'h20};
  logic [3:0] br_ccr   [9] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0111,
                               4'b0001, 4'b1110, 4'b0000};
  logic       br_taken [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic [6:0] s, input logic [3:0] alu,
                                      input logic [1:0] b1, input logic [1:0] b2,
                                      input logic wr, input logic hlt);
    return {s, alu, b1, b2, 1'b0, wr, hlt};
  endfunction

  task automatic push_fetch();
    sb_q.push_back(mk(S_MAR, 4'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    sb_q.push_back(mk(S_PCI, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    sb_q.push_back(mk(S_IR,  4'd0, 2'd0, 2'd2, 1'b0, 1'b0));
    sb_q.push_back(mk(S_0,   4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic push_addr(input logic branch);
    push_fetch();
    sb_q.push_back(mk(S_MAR, 4'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    sb_q.push_back(mk(branch ? S_0 : S_PCI, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic push_ld_imm(input logic to_a);
    push_addr(1'b0);
    sb_q.push_back(mk(to_a ? S_A : S_B, 4'd0, 2'd0, 2'd2, 1'b0, 1'b0));
  endtask

  task automatic push_ld_dir(input logic to_a);
    push_addr(1'b0);
    sb_q.push_back(mk(S_MAR, 4'd0, 2'd0, 2'd2, 1'b0, 1'b0));
    sb_q.push_back(mk(S_0,   4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    sb_q.push_back(mk(to_a ? S_A : S_B, 4'd0, 2'd0, 2'd2, 1'b0, 1'b0));
  endtask

  task automatic push_st_dir(input logic from_a);
    push_addr(1'b0);
    sb_q.push_back(mk(S_MAR, 4'd0, 2'd0, 2'd2, 1'b0, 1'b0));
    sb_q.push_back(mk(S_0, 4'd0, from_a ? 2'd1 : 2'd2, 2'd0, 1'b1, 1'b0));
  endtask

  task automatic push_alu(input logic [3:0] code);
    push_fetch();
    sb_q.push_back(mk(S_A | S_CCR, code, 2'd1, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic push_branch(input logic taken);
    push_addr(1'b1);
    if (taken) sb_q.push_back(mk(S_PCL, 4'd0, 2'd0, 2'd2, 1'b0, 1'b0));
    else       sb_q.push_back(mk(S_PCI, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(mk(S_0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b1));
  endtask

  // One clock of the reference datapath, optionally popping and comparing a scoreboard entry.
  task automatic cycle(input bit chk);
    logic [17:0] exp_v;
    logic [7:0]  bus1, bus2, opb, res;
    logic [8:0]  wide;
    logic        v, ld_ir, ld_mar, ld_pc, inc_pc, ld_a, ld_b, ld_ccr, wr;
    logic [7:0]  wr_addr;
    @(negedge clk);
    cyc++;
    if (chk) begin
      exp_v = sb_q.pop_front();
      check_eq($sformatf("cycle%0d", cyc), 32'(dut_vec), 32'(exp_v));
    end
    if (halted && first_halt == 0) first_halt = cyc;
    case (Bus1_Sel)
      2'b00:   bus1 = pc_m;
      2'b01:   bus1 = a_m;
      2'b10:   bus1 = b_m;
      default: bus1 = 8'h00;
    endcase
    opb = ALU_B_Sel ? mem[mar_m] : b_m;
    v = 1'b0;
    case (ALU_Sel)
      4'b0000: begin
        wide = {1'b0, bus1} + {1'b0, opb};
        v = (bus1[7] == opb[7]) && (wide[7] != bus1[7]);
      end
      4'b0001: begin
        wide = {1'b0, bus1} - {1'b0, opb};
        v = (bus1[7] != opb[7]) && (wide[7] != bus1[7]);
      end
      4'b0010: wide = {1'b0, bus1 & opb};
      4'b0011: wide = {1'b0, bus1 | opb};
      4'b0100: wide = {1'b0, bus1} + 9'd1;
      4'b0101: wide = {1'b0, bus1} - 9'd1;
      default: wide = 9'd0;
    endcase
    res = wide[7:0];
    case (Bus2_Sel)
      2'b00:   bus2 = res;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = mem[mar_m];
      default: bus2 = 8'h00;
    endcase
    ld_ir = IR_Load; ld_mar = MAR_Load; ld_pc = PC_Load; inc_pc = PC_Inc;
    ld_a = A_Load; ld_b = B_Load; ld_ccr = CCR_Load; wr = write; wr_addr = mar_m;
    @(posedge clk);
    #1;
    if (ld_ir)  ir_m = bus2;
    if (ld_pc)  pc_m = mar_m + bus2;
    else if (inc_pc) pc_m = pc_m + 8'd1;
    if (ld_mar) mar_m = bus2;
    if (ld_a)   a_m = bus2;
    if (ld_b)   b_m = bus2;
    if (ld_ccr) ccr_m = {res[7], res == 8'h00, v, wide[8]};
    if (wr)     mem[wr_addr] = bus1;
  endtask

  task automatic run_q();
    while (sb_q.size() > 0) cycle(1'b1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    a_m = 8'h00; b_m = 8'h00; mar_m = 8'h00; ccr_m = 4'h0;
  endtask

  // Reset is raised asynchronously, held across two edges, and dropped just after an edge.
  task automatic do_reset();
    reset = 1'b1;
    pc_m = 8'h00;
    #1;
    check_eq("reset_outputs", 32'(dut_vec), 32'(mk(S_0, 4'd0, 2'd0, 2'd1, 1'b0, 1'b0)));
    cycle(1'b0);
    cycle(1'b0);
    check_eq("reset_held_outputs", 32'(dut_vec), 32'(mk(S_0, 4'd0, 2'd0, 2'd1, 1'b0, 1'b0)));
    reset = 1'b0;
    #1;
    check_eq("reset_release_fetch0", 32'(dut_vec), 32'(mk(S_MAR, 4'd0, 2'd0, 2'd1, 1'b0, 1'b0)));
    cyc = 0;
    first_halt = 0;
  endtask

  initial begin
    clear_mem();
    pc_m = 8'h00;
    #3;

    // Immediate loads, ADD, then HLT.
    clear_mem();
    mem[8'h00] = 8'h86; mem[8'h01] = 8'h05; mem[8'h02] = 8'h88;
    mem[8'h03] = 8'h03; mem[8'h04] = 8'h42; mem[8'h05] = 8'hFF;
    do_reset();
    push_ld_imm(1'b1); push_ld_imm(1'b0); push_alu(4'b0000); push_fetch(); push_halt(3);
    run_q();
    check_eq("prog1_A", 32'(a_m), 32'h08);
    check_eq("prog1_B", 32'(b_m), 32'h03);
    check_eq("prog1_CCR", 32'(ccr_m), 32'h0);
    check_eq("prog1_halt_cycle", 32'(first_halt), 32'd24);

    // Direct load.
    clear_mem();
    mem[8'h00] = 8'h87; mem[8'h01] = 8'h10; mem[8'h02] = 8'hFF; mem[8'h10] = 8'h7F;
    do_reset();
    push_ld_dir(1'b1); push_fetch(); push_halt(2);
    run_q();
    check_eq("lda_dir_A", 32'(a_m), 32'h7F);

    // Direct store of A.
    clear_mem();
    mem[8'h00] = 8'h96; mem[8'h01] = 8'h20; mem[8'h02] = 8'hFF;
    do_reset();
    a_m = 8'hAA;
    push_st_dir(1'b1); push_fetch(); push_halt(2);
    run_q();
    check_eq("sta_dir_mem", 32'(mem[8'h20]), 32'hAA);

    // Every ALU op, then STB.
    clear_mem();
    mem[8'h00] = 8'h86; mem[8'h01] = 8'hF0; mem[8'h02] = 8'h88; mem[8'h03] = 8'h0F;
    mem[8'h04] = 8'h45; mem[8'h05] = 8'h47; mem[8'h06] = 8'h46; mem[8'h07] = 8'h43;
    mem[8'h08] = 8'h44; mem[8'h09] = 8'h97; mem[8'h0A] = 8'h30; mem[8'h0B] = 8'hFF;
    do_reset();
    push_ld_imm(1'b1); push_ld_imm(1'b0);
    push_alu(4'b0011); push_alu(4'b0101); push_alu(4'b0100); push_alu(4'b0001); push_alu(4'b0010);
    push_st_dir(1'b0); push_fetch(); push_halt(2);
    run_q();
    check_eq("alu_A", 32'(a_m), 32'h00);
    check_eq("alu_CCR", 32'(ccr_m), 32'h4);
    check_eq("stb_mem", 32'(mem[8'h30]), 32'h0F);

    // Conditional branches at 40 with offset 05.
    for (int k = 0; k < 9; k++) begin
      clear_mem();
      do_reset();
      pc_m = 8'h40;
      ccr_m = br_ccr[k];
      mem[8'h40] = br_op[k]; mem[8'h41] = 8'h05;
      push_branch(br_taken[k]);
      run_q();
      check_eq($sformatf("branch%0d_pc", k), 32'(pc_m), br_taken[k] ? 32'h46 : 32'h42);
    end

    // Undefined opcode halts and stays halted.
    clear_mem();
    mem[8'h00] = 8'h3C;
    do_reset();
    push_fetch(); push_halt(20);
    run_q();

    // Reset in the write cycle of STA_DIR.
    clear_mem();
    mem[8'h00] = 8'h96; mem[8'h01] = 8'h20; mem[8'h20] = 8'h11;
    do_reset();
    a_m = 8'hAA;
    push_addr(1'b0);
    sb_q.push_back(mk(S_MAR, 4'd0, 2'd0, 2'd2, 1'b0, 1'b0));
    run_q();
    #1;
    check_eq("exec7_write", 32'(write), 32'd1);
    do_reset();
    check_eq("reset_no_store", 32'(mem[8'h20]), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 clk  input  1  rising-edge clock shared with the datapath.
REQ-003 reset  input  1  asynchronous, active-high; forces state FETCH_0.
REQ-004 IR  input  8  current instruction register from the datapath.
REQ-005 CCR_Result  input  4  flags {N,Z,V,C}, bit3=N, bit0=C.
REQ-006 IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  output  1 each  datapath load strobes.
REQ-007 ALU_Sel  output  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 INC, 0101 DEC.
REQ-008 Bus1_Sel  output  2  00 PC, 01 A, 10 B.
REQ-009 Bus2_Sel  output  2  00 ALU, 01 BUS1, 10 memory.
REQ-010 ALU_B_Sel  output  1  0 = B register, 1 = BUS2.
REQ-011 write  output  1  memory write strobe; data = BUS1, address = MAR.
REQ-012 halted  output  1  high while in state HALT.

Function
REQ-013 All outputs SHALL be combinational functions of the registered state, IR and CCR_Result; every output SHALL be 0 in any state not listed as driving it.
REQ-014 Opcodes: 86 LDA_IMM, 87 LDA_DIR, 88 LDB_IMM, 89 LDB_DIR, 96 STA_DIR, 97 STB_DIR, 42 ADD_AB, 43 SUB_AB, 44 AND_AB, 45 OR_AB, 46 INCA, 47 DECA, 20 BRA, 21 BMI, 23 BEQ, 24 BNE, 25 BCS, FF HLT; all values are hex.
REQ-015 FETCH_0: Bus1_Sel=00, Bus2_Sel=01, MAR_Load=1; next state FETCH_1.
REQ-016 FETCH_1: PC_Inc=1; next state FETCH_2.
REQ-017 FETCH_2: Bus2_Sel=10, IR_Load=1; next state DECODE_3.
REQ-018 DECODE_3: no strobes; the next state is the first execute state for IR. Unknown opcodes and FF SHALL go to HALT.
REQ-019 Operand-address step, common to all non-ALU instructions: EXEC_4 sets MAR<=PC (as FETCH_0); EXEC_5 asserts PC_Inc, except for branches, which assert no strobes.
REQ-020 LDx_IMM: EXEC_6 drives Bus2_Sel=10 with A_Load (LDA) or B_Load (LDB), then FETCH_0; 7 cycles total.
REQ-021 LDx_DIR: EXEC_6 drives Bus2_Sel=10 with MAR_Load=1; EXEC_7 has no strobes; EXEC_8 drives Bus2_Sel=10 with A_Load or B_Load, then FETCH_0; 9 cycles total.
REQ-022 STx_DIR: EXEC_6 is as LDx_DIR; EXEC_7 drives Bus1_Sel=01 (A) or 10 (B) with write=1, then FETCH_0; 8 cycles total.
REQ-023 ALU ops: a single EXEC_4 drives Bus1_Sel=01, ALU_B_Sel=0, Bus2_Sel=00, the ALU_Sel from REQ-007, A_Load=1 and CCR_Load=1, then FETCH_0; 5 cycles total.
REQ-024 Branch condition: BRA always taken; BMI taken if N=1; BEQ if Z=1; BNE if Z=0; BCS if C=1; the condition is sampled in EXEC_6.
REQ-025 Branch EXEC_6, taken: PC_Load=1 with Bus2_Sel=10, so PC = operand address + offset (modulo 256, offset unsigned 8-bit).
REQ-026 Branch EXEC_6, not taken: PC_Inc=1 to skip the operand.
REQ-027 Branch next state after EXEC_6 is FETCH_0 in both the taken and not-taken cases; 7 cycles total.
REQ-028 PC_Load and PC_Inc SHALL never be asserted in the same cycle.
REQ-029 MAR_Load and write SHALL never be asserted in the same cycle.
REQ-030 HALT SHALL be absorbing: halted=1, all strobes 0; only reset exits it.
REQ-031 PC wrap (FF+1 -> 00) requires no special handling; the datapath performs the wrap.

Reset
REQ-032 Asserting reset SHALL force state FETCH_0 immediately, regardless of clk or the current state, including mid-instruction.
REQ-033 While reset is high, all strobes, write and halted SHALL be 0.
REQ-034 The first rising clk edge after reset deasserts SHALL leave FETCH_0, so MAR_Load=1 is visible from reset deassertion until that edge.

Verification
REQ-035 Memory {00:86,01:05,02:88,03:03,04:42,05:FF}, reset, run -> A=08, B=03, CCR Z=0 N=0 C=0; halted=1 at cycle 24.
REQ-036 LDA_DIR at 00 with operand 10, and mem[10]=7F -> A=7F after 9 cycles; write=0 throughout.
REQ-037 A=AA, STA_DIR with operand 20 -> mem[20]=AA; write is high for exactly 1 cycle, in EXEC_7.
REQ-038 Z=1, BEQ at 40 with offset 05 -> PC=46 after 7 cycles; the same with Z=0 -> PC=42, and PC_Load is never asserted.
REQ-039 Opcode 3C (undefined) -> HALT after DECODE_3; strobes stay 0 for 20 cycles; a reset pulse returns to FETCH_0.
REQ-040 Reset asserted in EXEC_7 of STA_DIR -> write=0 immediately; no memory write; state is FETCH_0.
